regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised, scoreboarded register file for the pipelined core; the next generation of the single-write, two-read file. It provides NUM_RD combinational read ports and two write-back ports: W0 for the ALU and W1 for load data. Every write port bypasses to the reads. A per-register busy scoreboard, set at issue and cleared at write-back, drives the decode-stage stall. A runtime-selectable debug tap replaces the fixed register taps.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers, register 0 hard-wired to zero
- NUM_RD, 2, number of read ports (1..4)

Ports:
- in_clk  in  1  clock; all state updates on the rising edge
- in_rst  in  1  reset, asynchronous, active-high
- in_rd_addr  in  NUM_RD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W]
- in_rd_ena  in  NUM_RD  read enable per port
- out_rd_data  out  NUM_RD*DATA_W  read data per port
- out_rd_busy  out  NUM_RD  per port: operand not yet available
- out_stall  out  1  OR of out_rd_busy
- in_w0_ena, in_w0_addr[ADDR_W], in_w0_data[DATA_W]  in  ALU write-back
- in_w1_ena, in_w1_addr[ADDR_W], in_w1_data[DATA_W]  in  load write-back
- in_iss_ena, in_iss_addr[ADDR_W]  in  issue: marks the destination register pending
- in_flush  in  1  clears all busy bits
- in_dbg_addr  in  ADDR_W  debug tap select
- out_dbg_data  out  DATA_W  registered array content at in_dbg_addr, no bypass
- out_wr_conflict  out  1  registered pulse: W0 and W1 targeted the same nonzero register in the previous cycle

## Operation
- Write: a port with ena=1 and addr≠0 updates array[addr] at the clock edge.
  - Both ports on the same nonzero addr: W0 wins, W1 is dropped, and out_wr_conflict=1 for the following cycle.
  - Writes to register 0 are ignored.
- Read, per port k (combinational), in priority order:
  1. in_rst=1 → 0.
  2. ena=0 → 0.
  3. addr=0 → 0.
  4. W0 writing the same addr → in_w0_data.
  5. W1 writing the same addr → in_w1_data.
  6. Otherwise → array[addr].
- Scoreboard busy[DEPTH], with busy[0] always 0:
  - Issue (in_iss_ena, addr≠0) sets busy[addr].
  - A write on W0 or W1 clears busy for its target.
  - Issue and write to the same register in the same cycle: the set wins, because the new producer is younger.
  - in_flush clears every busy bit and overrides issue in the same cycle. Register contents are unaffected.
- out_rd_busy[k] = ena & addr≠0 & busy[addr] & no write on W0/W1 to addr this cycle. A bypass therefore resolves the hazard without a stall.
- out_stall = |out_rd_busy. The block does not gate issue itself; the decode stage must hold in_iss_ena low while out_stall=1.

## Timing
- Write latency: 1 cycle to the array; 0 cycles to a read via bypass.
- A busy bit set by issue in cycle N is visible to reads from cycle N+1.
- out_wr_conflict and out_dbg_data are registered; out_dbg_data reflects the array after the edge.
- Reset values:
  - all array entries, busy bits and out_wr_conflict = 0, asynchronously;
  - while in_rst=1, out_rd_data=0, out_rd_busy=0, out_stall=0 and out_dbg_data=0.
- A write presented in the same cycle as reset deassertion is honoured on the first rising edge with in_rst=0.
- Reset asserted mid-operation discards all pending writes and busy state immediately.

## Structure
- Shared package regfile_pkg: default widths RF_DATA_W=32 and RF_ADDR_W=5, and the constant RF_ZERO_REG=0.
- Sub-module rf_read_port, instantiated NUM_RD times via generate. It holds:
  - the address-0 check,
  - the W0/W1 bypass priority,
  - the busy qualification for one port.
- The array, scoreboard, conflict flag and debug register live in the top level.

## Test plan
- Reset, then write W0 r5=0x1234_5678 → next cycle a read of r5 on port 0 returns 0x12345678; the same-cycle read already returns it via bypass.
- W0 r7=0xAAAA_0000 and W1 r7=0x5555_FFFF together → r7=0xAAAA0000, out_wr_conflict=1 for exactly one cycle, and the same-cycle bypass shows 0xAAAA0000.
- Issue r9, then read r9 next cycle → out_stall=1. When W1 writes r9=0x42, the same cycle shows out_stall=0 with data 0x42, and busy[9] is clear afterwards.
- Same-cycle issue r3 and W0 write r3 → busy[3] stays set; a read of r3 next cycle stalls.
- Write r0=0xFFFF_FFFF and issue r0 → reads of r0 return 0 with no stall; in_flush with r4 and r6 busy → both clear next cycle.
- Assert in_rst mid-stream with several registers written and busy set → all outputs drop to 0 immediately, and after release every register reads 0 and nothing is busy.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the scoreboarded register file.
package regfile_pkg;

  localparam int RF_DATA_W   = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;

endpackage : regfile_pkg

// File: rtl/regfile_sb_rf_read_port.sv
// One combinational read port: zero-register check, W0/W1 bypass priority
// and busy qualification against the scoreboard bit of the addressed register.
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              in_rst,
  input  logic              in_rd_ena,
  input  logic [ADDR_W-1:0] in_rd_addr,
  input  logic              in_w0_ena,
  input  logic [ADDR_W-1:0] in_w0_addr,
  input  logic [DATA_W-1:0] in_w0_data,
  input  logic              in_w1_ena,
  input  logic [ADDR_W-1:0] in_w1_addr,
  input  logic [DATA_W-1:0] in_w1_data,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic              in_busy,
  output logic [DATA_W-1:0] out_rd_data,
  output logic              out_rd_busy
);

  logic w_active;
  logic w_w0_hit;
  logic w_w1_hit;

  assign w_active = !in_rst && in_rd_ena && (in_rd_addr != ADDR_W'(RF_ZERO_REG));
  assign w_w0_hit = in_w0_ena && (in_w0_addr == in_rd_addr);
  assign w_w1_hit = in_w1_ena && (in_w1_addr == in_rd_addr);

  // Data select: W0 bypass beats W1 bypass beats the stored value.
  always_comb begin
    out_rd_data = '0;
    if (w_active) begin
      if (w_w0_hit)      out_rd_data = in_w0_data;
      else if (w_w1_hit) out_rd_data = in_w1_data;
      else               out_rd_data = in_mem_data;
    end
  end

  // A write-back landing this cycle resolves the hazard through the bypass.
  assign out_rd_busy = w_active && in_busy && !w_w0_hit && !w_w1_hit;

endmodule : rf_read_port

// File: rtl/regfile_sb.sv
// Scoreboarded register file: NUM_RD bypassed read ports, two write-back
// ports (W0 ALU, W1 load, W0 wins on collision), per-register busy bits
// driving the decode stall, and a registered debug tap.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     in_clk,
  input  logic                     in_rst,
  input  logic [NUM_RD*ADDR_W-1:0] in_rd_addr,
  input  logic [NUM_RD-1:0]        in_rd_ena,
  output logic [NUM_RD*DATA_W-1:0] out_rd_data,
  output logic [NUM_RD-1:0]        out_rd_busy,
  output logic                     out_stall,
  input  logic                     in_w0_ena,
  input  logic [ADDR_W-1:0]        in_w0_addr,
  input  logic [DATA_W-1:0]        in_w0_data,
  input  logic                     in_w1_ena,
  input  logic [ADDR_W-1:0]        in_w1_addr,
  input  logic [DATA_W-1:0]        in_w1_data,
  input  logic                     in_iss_ena,
  input  logic [ADDR_W-1:0]        in_iss_addr,
  input  logic                     in_flush,
  input  logic [ADDR_W-1:0]        in_dbg_addr,
  output logic [DATA_W-1:0]        out_dbg_data,
  output logic                     out_wr_conflict
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic              r_wr_conflict;
  logic [DATA_W-1:0] r_dbg;

  logic              w_w0_we;
  logic              w_w1_we;
  logic              w_iss_we;
  logic              w_conflict;
  logic [DATA_W-1:0] w_dbg_next;

  // Effective write enables; W1 is dropped when W0 owns the same register.
  assign w_w0_we    = in_w0_ena && (in_w0_addr != ADDR_W'(RF_ZERO_REG));
  assign w_conflict = w_w0_we && in_w1_ena && (in_w1_addr == in_w0_addr);
  assign w_w1_we    = in_w1_ena && (in_w1_addr != ADDR_W'(RF_ZERO_REG)) && !w_conflict;
  assign w_iss_we   = in_iss_ena && (in_iss_addr != ADDR_W'(RF_ZERO_REG));

  // Register array update.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_w0_we) r_mem[in_w0_addr] <= in_w0_data;
      if (w_w1_we) r_mem[in_w1_addr] <= in_w1_data;
    end
  end

  // Scoreboard: flush beats issue, issue (younger producer) beats write-back clear.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_busy <= '0;
    end else begin
      r_busy[0] <= 1'b0;
      for (int i = 1; i < DEPTH; i++) begin
        if (in_flush)
          r_busy[i] <= 1'b0;
        else if (w_iss_we && (in_iss_addr == ADDR_W'(i)))
          r_busy[i] <= 1'b1;
        else if ((w_w0_we && (in_w0_addr == ADDR_W'(i))) ||
                 (w_w1_we && (in_w1_addr == ADDR_W'(i))))
          r_busy[i] <= 1'b0;
      end
    end
  end

  // Debug tap shows the array as it stands after this edge's writes.
  always_comb begin
    w_dbg_next = r_mem[in_dbg_addr];
    if (in_dbg_addr == ADDR_W'(RF_ZERO_REG))             w_dbg_next = '0;
    else if (w_w0_we && (in_w0_addr == in_dbg_addr)) w_dbg_next = in_w0_data;
    else if (w_w1_we && (in_w1_addr == in_dbg_addr)) w_dbg_next = in_w1_data;
  end

  // Registered conflict pulse and debug tap.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_wr_conflict <= 1'b0;
      r_dbg         <= '0;
    end else begin
      r_wr_conflict <= w_conflict;
      r_dbg         <= w_dbg_next;
    end
  end

  assign out_wr_conflict = r_wr_conflict;
  assign out_dbg_data    = r_dbg;

  // Read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = in_rd_addr[k*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_port (
      .in_rst      (in_rst),
      .in_rd_ena   (in_rd_ena[k]),
      .in_rd_addr  (w_addr),
      .in_w0_ena   (w_w0_we),
      .in_w0_addr  (in_w0_addr),
      .in_w0_data  (in_w0_data),
      .in_w1_ena   (w_w1_we),
      .in_w1_addr  (in_w1_addr),
      .in_w1_data  (in_w1_data),
      .in_mem_data (r_mem[w_addr]),
      .in_busy     (r_busy[w_addr]),
      .out_rd_data (out_rd_data[k*DATA_W +: DATA_W]),
      .out_rd_busy (out_rd_busy[k])
    );
  end

  assign out_stall = |out_rd_busy;

endmodule : regfile_sb

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with two read ports.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic             in_clk;
  logic             in_rst;
  logic [NR*AW-1:0] in_rd_addr;
  logic [NR-1:0]    in_rd_ena;
  logic [NR*DW-1:0] out_rd_data;
  logic [NR-1:0]    out_rd_busy;
  logic             out_stall;
  logic             in_w0_ena;
  logic [AW-1:0]    in_w0_addr;
  logic [DW-1:0]    in_w0_data;
  logic             in_w1_ena;
  logic [AW-1:0]    in_w1_addr;
  logic [DW-1:0]    in_w1_data;
  logic             in_iss_ena;
  logic [AW-1:0]    in_iss_addr;
  logic             in_flush;
  logic [AW-1:0]    in_dbg_addr;
  logic [DW-1:0]    out_dbg_data;
  logic             out_wr_conflict;

  int checks = 0;
  int errors = 0;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_rd_addr      (in_rd_addr),
    .in_rd_ena       (in_rd_ena),
    .out_rd_data     (out_rd_data),
    .out_rd_busy     (out_rd_busy),
    .out_stall       (out_stall),
    .in_w0_ena       (in_w0_ena),
    .in_w0_addr      (in_w0_addr),
    .in_w0_data      (in_w0_data),
    .in_w1_ena       (in_w1_ena),
    .in_w1_addr      (in_w1_addr),
    .in_w1_data      (in_w1_data),
    .in_iss_ena      (in_iss_ena),
    .in_iss_addr     (in_iss_addr),
    .in_flush        (in_flush),
    .in_dbg_addr     (in_dbg_addr),
    .out_dbg_data    (out_dbg_data),
    .out_wr_conflict (out_wr_conflict)
  );

  // Clock
  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] ena, input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    in_rd_ena  = ena;
    in_rd_addr = {a1, a0};
  endtask

  task automatic idle_wr();
    in_w0_ena  = 1'b0;
    in_w1_ena  = 1'b0;
    in_iss_ena = 1'b0;
    in_flush   = 1'b0;
  endtask

  initial begin
    // Reset state
    in_rst = 1'b1;
    idle_wr();
    in_w0_addr = '0; in_w0_data = '0;
    in_w1_addr = '0; in_w1_data = '0;
    in_iss_addr = '0; in_dbg_addr = 5'd5;
    rd(2'b11, 5'd6, 5'd5);
    repeat (2) @(negedge in_clk);
    #1;
    chk("rst_rd_data", out_rd_data, 64'h0);
    chk("rst_rd_busy", out_rd_busy, 2'b00);
    chk("rst_stall",   out_stall, 1'b0);
    chk("rst_dbg",     out_dbg_data, 32'h0);
    chk("rst_conflict", out_wr_conflict, 1'b0);

    // Release reset with a W0 write presented; bypass visible at once
    @(negedge in_clk);
    in_rst = 1'b0;
    in_w0_ena = 1'b1; in_w0_addr = 5'd5; in_w0_data = 32'h1234_5678;
    #1;
    chk("r5_bypass", out_rd_data, {32'h0, 32'h1234_5678});

    @(negedge in_clk);
    idle_wr();
    #1;
    chk("r5_array", out_rd_data[31:0], 32'h1234_5678);
    chk("dbg_r5",   out_dbg_data, 32'h1234_5678);

    // W0/W1 collision on r7
    @(negedge in_clk);
    in_w0_ena = 1'b1; in_w0_addr = 5'd7; in_w0_data = 32'hAAAA_0000;
    in_w1_ena = 1'b1; in_w1_addr = 5'd7; in_w1_data = 32'h5555_FFFF;
    rd(2'b11, 5'd7, 5'd5);
    #1;
    chk("r7_bypass_w0", out_rd_data[63:32], 32'hAAAA_0000);
    chk("conflict_pre", out_wr_conflict, 1'b0);

    @(negedge in_clk);
    idle_wr();
    #1;
    chk("conflict_pulse", out_wr_conflict, 1'b1);
    chk("r7_array",       out_rd_data[63:32], 32'hAAAA_0000);

    // Issue r9; busy not visible during the issue cycle
    @(negedge in_clk);
    in_iss_ena = 1'b1; in_iss_addr = 5'd9;
    rd(2'b11, 5'd7, 5'd9);
    #1;
    chk("conflict_end", out_wr_conflict, 1'b0);
    chk("iss_same_cycle_stall", out_stall, 1'b0);

    @(negedge in_clk);
    idle_wr();
    #1;
    chk("r9_busy",  out_rd_busy, 2'b01);
    chk("r9_stall", out_stall, 1'b1);

    // W1 write-back to r9 resolves through the bypass
    @(negedge in_clk);
    in_w1_ena = 1'b1; in_w1_addr = 5'd9; in_w1_data = 32'h42;
    #1;
    chk("r9_wb_stall", out_stall, 1'b0);
    chk("r9_wb_data",  out_rd_data[31:0], 32'h42);

    @(negedge in_clk);
    idle_wr();
    #1;
    chk("r9_clear_stall", out_stall, 1'b0);
    chk("r9_array",       out_rd_data[31:0], 32'h42);

    // Same-cycle issue and W0 write of r3: set wins
    @(negedge in_clk);
    in_iss_ena = 1'b1; in_iss_addr = 5'd3;
    in_w0_ena = 1'b1; in_w0_addr = 5'd3; in_w0_data = 32'h33;
    rd(2'b11, 5'd3, 5'd9);
    #1;
    chk("r3_bypass", out_rd_data[63:32], 32'h33);
    chk("r3_busy_same", out_rd_busy, 2'b00);

    @(negedge in_clk);
    idle_wr();
    #1;
    chk("r3_busy_kept", out_rd_busy, 2'b10);
    chk("r3_stall",     out_stall, 1'b1);
    chk("r3_data",      out_rd_data[63:32], 32'h33);

    // Register 0: writes and issue ignored; disabled port reads 0
    @(negedge in_clk);
    in_w0_ena = 1'b1; in_w0_addr = 5'd0; in_w0_data = 32'hFFFF_FFFF;
    in_iss_ena = 1'b1; in_iss_addr = 5'd0;
    rd(2'b01, 5'd3, 5'd0);
    #1;
    chk("r0_bypass", out_rd_data, 64'h0);
    chk("r0_stall",  out_stall, 1'b0);

    @(negedge in_clk);
    idle_wr();
    in_iss_ena = 1'b1; in_iss_addr = 5'd4;
    #1;
    chk("r0_after", out_rd_data[31:0], 32'h0);
    chk("r0_after_stall", out_stall, 1'b0);

    // Busy r4 and r6, then flush (with a competing issue of r4)
    @(negedge in_clk);
    in_iss_ena = 1'b1; in_iss_addr = 5'd6;
    rd(2'b11, 5'd6, 5'd4);
    #1;
    chk("r4_busy_r6_not", out_rd_busy, 2'b01);

    @(negedge in_clk);
    in_iss_ena = 1'b1; in_iss_addr = 5'd4;
    in_flush = 1'b1;
    #1;
    chk("pre_flush_busy", out_rd_busy, 2'b11);

    @(negedge in_clk);
    idle_wr();
    #1;
    chk("post_flush_busy", out_rd_busy, 2'b00);
    rd(2'b11, 5'd3, 5'd5);
    #1;
    chk("post_flush_r3", out_rd_busy, 2'b00);
    chk("flush_keeps_data", out_rd_data, {32'h33, 32'h1234_5678});

    // Build state, then reset mid-cycle
    @(negedge in_clk);
    in_iss_ena = 1'b1; in_iss_addr = 5'd4;
    in_w0_ena = 1'b1; in_w0_addr = 5'd10; in_w0_data = 32'hDEAD;
    in_dbg_addr = 5'd7;

    @(negedge in_clk);
    idle_wr();
    in_w0_ena = 1'b1; in_w0_addr = 5'd11; in_w0_data = 32'hBEEF;
    rd(2'b11, 5'd10, 5'd4);
    #1;
    chk("pre_rst_stall", out_stall, 1'b1);
    chk("pre_rst_r10",   out_rd_data[63:32], 32'hDEAD);
    chk("pre_rst_dbg",   out_dbg_data, 32'hAAAA_0000);
    in_rst = 1'b1;
    #1;
    chk("midrst_rd_data", out_rd_data, 64'h0);
    chk("midrst_busy",    out_rd_busy, 2'b00);
    chk("midrst_stall",   out_stall, 1'b0);
    chk("midrst_dbg",     out_dbg_data, 32'h0);

    @(negedge in_clk);
    in_rst = 1'b0;
    idle_wr();
    rd(2'b11, 5'd7, 5'd5);
    #1;
    chk("post_rst_r5_r7", out_rd_data, 64'h0);

    @(negedge in_clk);
    rd(2'b11, 5'd11, 5'd10);
    #1;
    chk("post_rst_r10_r11", out_rd_data, 64'h0);
    chk("post_rst_dbg",     out_dbg_data, 32'h0);
    rd(2'b11, 5'd9, 5'd4);
    #1;
    chk("post_rst_busy",    out_rd_busy, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_regfile_sb
